// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared tagged memory port: Dcache priority with an Icache
// starvation guard, plus a tag ownership table that steers load returns to their requester.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned AddrW        = 32,
   parameter int unsigned BlockW       = 64,
   parameter int unsigned TagW         = 4,
   parameter int unsigned NumMemTags   = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        Icache2mem_command,
   input  logic [AddrW-1:0]  Icache2mem_addr,
   input  logic [1:0]        Dcache2mem_command,
   input  logic [AddrW-1:0]  Dcache2mem_addr,
   input  logic [BlockW-1:0] Dcache2mem_data,
   input  logic [TagW-1:0]   mem2proc_transaction_tag,
   input  logic [BlockW-1:0] mem2proc_data,
   input  logic [TagW-1:0]   mem2proc_data_tag,
   output logic [1:0]        proc2mem_command,
   output logic [AddrW-1:0]  proc2mem_addr,
   output logic [BlockW-1:0] proc2mem_data,
   output logic [TagW-1:0]   mem2Icache_transaction_tag,
   output logic [TagW-1:0]   mem2Icache_data_tag,
   output logic [BlockW-1:0] mem2Icache_data,
   output logic [TagW-1:0]   mem2Dcache_transaction_tag,
   output logic [TagW-1:0]   mem2Dcache_data_tag,
   output logic [BlockW-1:0] mem2Dcache_data,
   output logic [4:0]        i_outstanding,
   output logic [4:0]        d_outstanding
);

   localparam logic [1:0] MEM_NONE = 2'd0;
   localparam logic [1:0] MEM_LOAD = 2'd1;
   localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);

   // owner bit: 1 = Dcache, 0 = Icache; entry 0 is never allocated
   logic [NumMemTags:0] valid_q, valid_d;
   logic [NumMemTags:0] owner_q, owner_d;
   logic [StreakW-1:0]  streak_q, streak_d;
   logic [4:0]          i_out_q, i_out_d;
   logic [4:0]          d_out_q, d_out_d;

   logic i_valid, d_valid, grant_i, grant_d, accepted;
   logic alloc_i, alloc_d, ret_hit, ret_to_i, ret_to_d;

   // Requests are masked while reset is low so nothing is granted or routed.
   assign i_valid  = reset & (Icache2mem_command == MEM_LOAD);
   assign d_valid  = reset & (Dcache2mem_command != MEM_NONE);
   assign grant_d  = d_valid & ~(i_valid & (streak_q == StreakW'(STARVE_LIMIT)));
   assign grant_i  = i_valid & ~grant_d;
   assign accepted = (mem2proc_transaction_tag != '0);

   assign alloc_i  = grant_i & accepted;
   assign alloc_d  = grant_d & accepted & (Dcache2mem_command == MEM_LOAD);
   assign ret_hit  = reset & (mem2proc_data_tag != '0) & valid_q[mem2proc_data_tag];
   assign ret_to_d = ret_hit & owner_q[mem2proc_data_tag];
   assign ret_to_i = ret_hit & ~owner_q[mem2proc_data_tag];

   always_comb begin
      proc2mem_command = MEM_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (grant_d) begin
         proc2mem_command = Dcache2mem_command;
         proc2mem_addr    = Dcache2mem_addr;
         proc2mem_data    = Dcache2mem_data;
      end else if (grant_i) begin
         proc2mem_command = MEM_LOAD;
         proc2mem_addr    = Icache2mem_addr;
      end
   end

   assign mem2Icache_transaction_tag = grant_i ? mem2proc_transaction_tag : '0;
   assign mem2Dcache_transaction_tag = grant_d ? mem2proc_transaction_tag : '0;
   assign mem2Icache_data_tag        = ret_to_i ? mem2proc_data_tag : '0;
   assign mem2Dcache_data_tag        = ret_to_d ? mem2proc_data_tag : '0;
   assign mem2Icache_data            = ret_to_i ? mem2proc_data : '0;
   assign mem2Dcache_data            = ret_to_d ? mem2proc_data : '0;
   assign i_outstanding              = i_out_q;
   assign d_outstanding              = d_out_q;

   // Free before allocate so a same-cycle reuse of a tag keeps the new owner.
   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      if (ret_hit) begin
         valid_d[mem2proc_data_tag] = 1'b0;
      end
      if (alloc_i || alloc_d) begin
         valid_d[mem2proc_transaction_tag] = 1'b1;
         owner_d[mem2proc_transaction_tag] = alloc_d;
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (!i_valid || alloc_i) begin
         streak_d = '0;
      end else if (d_valid && grant_d && accepted && (streak_q != StreakW'(STARVE_LIMIT))) begin
         streak_d = streak_q + 1'b1;
      end
   end

   assign i_out_d = i_out_q + 5'(alloc_i) - 5'(ret_to_i);
   assign d_out_d = d_out_q + 5'(alloc_d) - 5'(ret_to_d);

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q  <= '0;
         owner_q  <= '0;
         streak_q <= '0;
         i_out_q  <= '0;
         d_out_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
         i_out_q  <= i_out_d;
         d_out_q  <= d_out_d;
      end
   end

endmodule
